// File: rtl/keypad_pkg.sv
// Shared constants for the keypad emulator and scanner benches: FSM encoding,
// key field slices and the counter width rule.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BNC_IN  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_BNC_OUT = 3'd3,
        ST_GAP     = 3'd4
    } kp_state_e;

    localparam int KEY_ROW_HI = 3;
    localparam int KEY_ROW_LO = 2;
    localparam int KEY_COL_HI = 1;
    localparam int KEY_COL_LO = 0;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[KEY_ROW_HI:KEY_ROW_LO];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[KEY_COL_HI:KEY_COL_LO];
    endfunction

    // Wide enough for the longest phase so the counter can saturate instead of wrapping.
    function automatic int cnt_width(input int bounce_cyc, input int gap_cyc, input int hold_w);
        int max_v;
        max_v = 1 << hold_w;
        if (bounce_cyc > max_v) begin
            max_v = bounce_cyc;
        end else begin
            max_v = max_v;
        end
        if (gap_cyc > max_v) begin
            max_v = gap_cyc;
        end else begin
            max_v = max_v;
        end
        return $clog2(max_v) + 1;
    endfunction

endpackage

// File: rtl/keypad_matrix_drive.sv
// Combinational column drive for one closed key of a 4x4 active-low matrix.
module keypad_matrix_drive
    import keypad_pkg::*;
(
    input  logic       contact_s,
    input  logic [3:0] key_s,
    input  logic [3:0] row_s,
    output logic [3:0] col_s
);

    // Pull the key's column low only while its own row is being driven low.
    always_comb begin
        col_s = 4'b1111;
        if (contact_s && (row_s[key_row(key_s)] == 1'b0)) begin
            col_s[key_col(key_s)] = 1'b0;
        end else begin
            col_s = 4'b1111;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad stand-in: presses one key for a commanded time, with contact bounce on
// make and break, and answers the scanner's row drive on the column lines.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYC = 8,
    parameter int BOUNCE_PER = 2,
    parameter int GAP_CYC    = 16,
    parameter int HOLD_W     = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req,
    input  logic [3:0]        i_Key,
    input  logic [HOLD_W-1:0] i_HoldCyc,
    input  logic [3:0]        i_Row,
    output logic [3:0]        o_Col,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam int CNT_W = cnt_width(BOUNCE_CYC, GAP_CYC, HOLD_W);
    localparam int TOG_W = (BOUNCE_PER > 1) ? $clog2(BOUNCE_PER) : 1;
    localparam logic [CNT_W-1:0] BNC_LAST = CNT_W'((BOUNCE_CYC > 0) ? BOUNCE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 1) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'((BOUNCE_PER > 1) ? BOUNCE_PER - 1 : 0);

    kp_state_e         state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_inc_s, hold_last_s;
    logic [TOG_W-1:0]  tog_r, tog_s;
    logic              tog_wrap_s;
    logic              contact_r, contact_s;
    logic [3:0]        key_r, key_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    assign hold_last_s = CNT_W'(hold_r) - CNT_W'(1);
    assign tog_wrap_s  = (tog_r == TOG_LAST);

    // Next-state, counter reload on every state entry, bounce toggling and handshake flags.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_inc_s;
        tog_s     = tog_wrap_s ? {TOG_W{1'b0}} : tog_r + TOG_W'(1);
        contact_s = contact_r;
        key_s     = key_r;
        hold_s    = hold_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s     = {CNT_W{1'b0}};
                tog_s     = {TOG_W{1'b0}};
                contact_s = 1'b0;
                if (i_Req) begin
                    key_s     = i_Key;
                    hold_s    = (i_HoldCyc == {HOLD_W{1'b0}}) ? HOLD_W'(1) : i_HoldCyc;
                    contact_s = 1'b1;
                    state_s   = (BOUNCE_CYC == 0) ? ST_HOLD : ST_BNC_IN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BNC_IN: begin
                if (cnt_r == BNC_LAST) begin
                    state_s   = ST_HOLD;
                    cnt_s     = {CNT_W{1'b0}};
                    tog_s     = {TOG_W{1'b0}};
                    contact_s = 1'b1;
                end else begin
                    contact_s = tog_wrap_s ? ~contact_r : contact_r;
                end
            end
            ST_HOLD: begin
                if (cnt_r == hold_last_s) begin
                    state_s   = (BOUNCE_CYC == 0) ? ST_GAP : ST_BNC_OUT;
                    cnt_s     = {CNT_W{1'b0}};
                    tog_s     = {TOG_W{1'b0}};
                    contact_s = 1'b0;
                end else begin
                    contact_s = 1'b1;
                end
            end
            ST_BNC_OUT: begin
                if (cnt_r == BNC_LAST) begin
                    state_s   = ST_GAP;
                    cnt_s     = {CNT_W{1'b0}};
                    tog_s     = {TOG_W{1'b0}};
                    contact_s = 1'b0;
                end else begin
                    contact_s = tog_wrap_s ? ~contact_r : contact_r;
                end
            end
            ST_GAP: begin
                contact_s = 1'b0;
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = {CNT_W{1'b0}};
                tog_s     = {TOG_W{1'b0}};
                contact_s = 1'b0;
            end
        endcase
        // Done marks the last gap cycle; busy drops together with it.
        done_s = (state_s == ST_GAP) && (cnt_s == GAP_LAST);
        busy_s = (state_s != ST_IDLE) && !done_s;
    end

    // State, counters, contact and latched command.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            tog_r     <= {TOG_W{1'b0}};
            contact_r <= 1'b0;
            key_r     <= 4'h0;
            hold_r    <= {HOLD_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            tog_r     <= tog_s;
            contact_r <= contact_s;
            key_r     <= key_s;
            hold_r    <= hold_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign o_Busy = busy_r;
    assign o_Done = done_r;

    keypad_matrix_drive u_drive (
        .contact_s (contact_r),
        .key_s     (key_r),
        .row_s     (i_Row),
        .col_s     (o_Col)
    );

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: a bouncing instance and a clean-edge instance,
// checked every cycle against a timeline model plus hand-computed literals.
module tb_keypad_emulator;

    localparam int PER = 2;
    localparam int GAP = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_v;
    logic [1:0][3:0] key_v;
    logic [1:0][7:0] hold_v;
    logic [1:0][3:0] row_v;
    logic [1:0][3:0] col_v;
    logic [1:0]      busy_v;
    logic [1:0]      done_v;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;
    int cyc      = 0;

    bit       m_act   [2];
    int       m_start [2];
    int       m_key   [2];
    int       m_hold  [2];

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYC(8), .BOUNCE_PER(PER), .GAP_CYC(GAP), .HOLD_W(8)) dut0 (
        .i_Clk(clk), .i_Rst(rst_n), .i_Req(req_v[0]), .i_Key(key_v[0]), .i_HoldCyc(hold_v[0]),
        .i_Row(row_v[0]), .o_Col(col_v[0]), .o_Busy(busy_v[0]), .o_Done(done_v[0])
    );

    keypad_emulator #(.BOUNCE_CYC(0), .BOUNCE_PER(PER), .GAP_CYC(GAP), .HOLD_W(8)) dut1 (
        .i_Clk(clk), .i_Rst(rst_n), .i_Req(req_v[1]), .i_Key(key_v[1]), .i_HoldCyc(hold_v[1]),
        .i_Row(row_v[1]), .o_Col(col_v[1]), .o_Busy(busy_v[1]), .o_Done(done_v[1])
    );

    function automatic int bnc(input int i);
        return (i == 0) ? 8 : 0;
    endfunction

    function automatic int total(input int i);
        return 2 * bnc(i) + m_hold[i] + GAP;
    endfunction

    // Contact closure at offset d of a press: bounce in, hold, bounce out, gap.
    function automatic bit exp_contact(input int d, input int b, input int h);
        if (d < b) return ((d / PER) % 2) == 0;
        else if (d < b + h) return 1'b1;
        else if (d < 2 * b + h) return (((d - b - h) / PER) % 2) == 1;
        else return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: commands are accepted only after the previous one has fully ended.
    initial begin
        for (int i = 0; i < 2; i++) m_act[i] = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_act[i] = 1'b0;
                end else if (!m_act[i] || ((cyc - 1 - m_start[i]) >= total(i))) begin
                    m_act[i] = 1'b0;
                    if (req_v[i]) begin
                        m_act[i]   = 1'b1;
                        m_start[i] = cyc;
                        m_key[i]   = int'(key_v[i]);
                        m_hold[i]  = (hold_v[i] == 8'd0) ? 1 : int'(hold_v[i]);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            for (int i = 0; i < 2; i++) m_act[i] = 1'b0;
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int i = 0; i < 2; i++) begin
                    int d;
                    bit act;
                    bit c;
                    logic [3:0] ec;
                    d   = cyc - m_start[i];
                    act = m_act[i] && (d < total(i));
                    c   = act && exp_contact(d, bnc(i), m_hold[i]);
                    ec  = 4'b1111;
                    if (c && row_v[i][m_key[i] / 4] == 1'b0) ec[m_key[i] % 4] = 1'b0;
                    check($sformatf("col%0d", i), 32'(col_v[i]), 32'(ec));
                    check($sformatf("busy%0d", i), 32'(busy_v[i]), 32'(act && (d < total(i) - 1)));
                    check($sformatf("done%0d", i), 32'(done_v[i]), 32'(act && (d == total(i) - 1)));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input int i, input logic [3:0] k, input logic [7:0] h, input logic [3:0] r);
        key_v[i]  = k;
        hold_v[i] = h;
        row_v[i]  = r;
        req_v[i]  = 1'b1;
        tick(1);
        req_v[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i, output int waited);
        waited = 0;
        while (done_v[i] !== 1'b1 && waited < 400) begin
            tick(1);
            waited++;
        end
        check("done_timeout", 32'(waited < 400), 32'd1);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1);
    end

    initial begin
        int w;
        int cnt;
        int done_at;
        int first_low;
        int d1;
        int d2;
        logic [35:0] v;
        logic [3:0] c7;
        logic [3:0] c8;
        logic [3:0] c9;
        logic b33;
        logic b34;

        rst_n  = 1'b0;
        req_v  = 2'b00;
        key_v  = '0;
        hold_v = '0;
        row_v  = {4'hF, 4'hF};
        tick(2);
        check("rst_col", 32'(col_v[0]), 32'hF);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        rst_n = 1'b1;
        tick(1);
        cmp_en = 1'b1;

        // Reset in the middle of a hold.
        issue(0, 4'h5, 8'd20, 4'b1101);
        tick(10);
        check("t1_hold_col", 32'(col_v[0]), 32'hD);
        rst_n = 1'b0;
        #1;
        check("t1_rst_col", 32'(col_v[0]), 32'hF);
        check("t1_rst_busy", 32'(busy_v[0]), 32'd0);
        tick(1);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_v[0]) cnt++;
            tick(1);
        end
        check("t1_no_done", 32'(cnt), 32'd0);

        // Clean edges: wrong row stays open, selected row shows the key for exactly the hold.
        issue(1, 4'h6, 8'd10, 4'b1110);
        wait_done(1, w);
        check("t2_done_offset_a", 32'(w), 32'd25);
        issue(1, 4'h6, 8'd10, 4'b1101);
        cnt = 0; done_at = -1; first_low = -1;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (col_v[1] == 4'b1011) begin
                cnt++;
                if (first_low < 0) first_low = k;
            end
            if (done_v[1]) done_at = k;
            @(posedge clk);
            #2;
        end
        check("t2_low_cycles", 32'(cnt), 32'd10);
        check("t2_first_low", 32'(first_low), 32'd0);
        check("t2_done_offset_b", 32'(done_at), 32'd25);

        // Default bounce on key 0.
        issue(0, 4'h0, 8'd4, 4'b1110);
        done_at = -1;
        for (int k = 0; k < 36; k++) begin
            #1;
            v[k] = col_v[0][0];
            if (done_v[0]) done_at = k;
            @(posedge clk);
            #2;
        end
        check("t3_bounce_in", 32'(v[7:0]), 32'hCC);
        check("t3_hold", 32'(v[11:8]), 32'h0);
        check("t3_bounce_out", 32'(v[19:12]), 32'h33);
        check("t3_gap", 32'(v[35:20]), 32'hFFFF);
        check("t3_done_offset", 32'(done_at), 32'd35);

        // A request while busy is dropped.
        issue(0, 4'h9, 8'd6, 4'b1011);
        tick(3);
        key_v[0] = 4'hF;
        req_v[0] = 1'b1;
        tick(5);
        req_v[0] = 1'b0;
        tick(2);
        check("t4_hold_col", 32'(col_v[0]), 32'hD);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_v[0]) cnt++;
            tick(1);
        end
        check("t4_single_done", 32'(cnt), 32'd1);

        // Zero hold and a continuously asserted request.
        key_v[0]  = 4'h3;
        hold_v[0] = 8'd0;
        row_v[0]  = 4'b1110;
        req_v[0]  = 1'b1;
        tick(1);
        d1 = -1; d2 = -1;
        c7 = 4'h0; c8 = 4'h0; c9 = 4'h0; b33 = 1'b1; b34 = 1'b0;
        for (int k = 0; k < 80; k++) begin
            #1;
            if (done_v[0]) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == 7) c7 = col_v[0];
            if (k == 8) c8 = col_v[0];
            if (k == 9) c9 = col_v[0];
            if (k == 33) b33 = busy_v[0];
            if (k == 34) b34 = busy_v[0];
            @(posedge clk);
            #2;
        end
        req_v[0] = 1'b0;
        check("t5_col_d7", 32'(c7), 32'hF);
        check("t5_col_hold", 32'(c8), 32'h7);
        check("t5_col_d9", 32'(c9), 32'hF);
        check("t5_first_done", 32'(d1), 32'd32);
        check("t5_second_done", 32'(d2), 32'd66);
        check("t5_idle_gap_busy", 32'(b33), 32'd0);
        check("t5_next_busy", 32'(b34), 32'd1);
        wait_done(0, w);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
